// File: rtl/dfp_round_sched.sv
// Round-robin scheduler sharing one decimal-float rounder among NREQ producers.
// A shadow {v, tag} pipeline mirrors the rounder; back-pressure freezes both via rnd_ce.
module dfp_round_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 4,
    parameter int TW   = $clog2(NREQ),
    parameter int UNW  = 136,
    parameter int DW   = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][2:0]      req_rm,
    input  logic [NREQ-1:0][UNW-1:0]  req_i,
    output logic                      rnd_ce,
    output logic [2:0]                rnd_rm,
    output logic [UNW-1:0]            rnd_i,
    input  logic [DW-1:0]             rnd_o,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [TW-1:0]             res_tag,
    output logic [DW-1:0]             res_o,
    output logic                      busy,
    output logic [$clog2(LAT+1)-1:0]  inflight,
    output logic [31:0]               stall_cnt
);

    localparam int CW = $clog2(LAT+1);

    logic [TW-1:0]          ptr;
    logic [LAT-1:0]         sh_v;
    logic [LAT-1:0][TW-1:0] sh_tag;
    logic [CW-1:0]          cnt;

    logic                   stall;
    logic                   any_gnt;
    logic [TW-1:0]          win;
    logic [TW-1:0]          sel;
    logic [NREQ-1:0]        gnt;

    assign stall     = res_valid & ~res_ready;
    assign rnd_ce    = ~stall;
    assign res_valid = sh_v[LAT-1];
    assign res_tag   = sh_tag[LAT-1];
    assign res_o     = rnd_o;
    assign inflight  = cnt;
    assign busy      = (cnt != '0);

    // Search starts one past the last winner; with no winner the mux parks on ptr+1.
    always_comb begin
        int j;
        any_gnt = 1'b0;
        win     = '0;
        gnt     = '0;
        j       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!any_gnt && req_valid[j]) begin
                any_gnt = 1'b1;
                win     = TW'(j);
            end
        end
        if (any_gnt) begin
            gnt[win] = 1'b1;
        end
        sel = any_gnt ? win : TW'((int'(ptr) + 1) % NREQ);
    end

    assign req_ready = rst ? '0 : (gnt & {NREQ{rnd_ce}});
    assign rnd_i     = req_i[sel];
    assign rnd_rm    = req_rm[sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= TW'(NREQ - 1);
            sh_v      <= '0;
            sh_tag    <= '0;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (rnd_ce) begin
                sh_v[0]   <= any_gnt;
                sh_tag[0] <= sel;
                for (int i = 1; i < LAT; i++) begin
                    sh_v[i]   <= sh_v[i-1];
                    sh_tag[i] <= sh_tag[i-1];
                end
                // Leaving op is the last stage; entering op is this cycle's grant.
                cnt <= cnt + CW'(any_gnt) - CW'(sh_v[LAT-1]);
                if (any_gnt) begin
                    ptr <= win;
                end
            end
        end
    end

endmodule
